// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg : shared types, byte-layout helpers and GF(2^8) arithmetic for the
//           AES inverse-cipher round engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [127:0] block_t;

    localparam int c_NB     = 4;
    localparam int c_NBYTES = 16;

    // Bits 10, 12 and 14 set: AES-128/192/256 round counts.
    localparam logic [15:0] c_LEGAL_ROUNDS = 16'h5400;

    function automatic bit rounds_legal(int r);
        return (r >= 0) && (r < 16) && c_LEGAL_ROUNDS[r[3:0]];
    endfunction

    // State byte s[r][c] lives at byte index 4c+r; byte 0 is the most significant.
    function automatic int byte_idx(int r, int c);
        return 4 * c + r;
    endfunction

    function automatic int byte_lsb(int k);
        return 120 - 8 * k;
    endfunction

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(logic [7:0] x);
        logic [7:0] y;
        logic [7:0] r;
        y = gf_mul(x, x);
        r = y;
        for (int i = 0; i < 6; i++) begin
            y = gf_mul(y, y);
            r = gf_mul(r, y);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_round_dp.sv
// ============================================================================
// aes_inv_round_dp : one combinational inverse-cipher round.
//                    InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_inv_round_dp
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    input  logic         i_last_round,
    output logic [127:0] o_state
);

    block_t     w_shifted;
    block_t     w_subbed;
    block_t     w_keyed;
    block_t     w_mixed;
    logic [7:0] w_acc;

    function automatic logic [7:0] imc_coef(int k);
        case (k)
            0:       return 8'h0e;
            1:       return 8'h0b;
            2:       return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

    // Row r rotates right by r columns.
    always_comb begin
        w_shifted = '0;
        for (int c = 0; c < c_NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shifted[byte_lsb(byte_idx(r, c)) +: 8] =
                    i_state[byte_lsb(byte_idx(r, (c - r + c_NB) % c_NB)) +: 8];
            end
        end
    end

    aes_inv_sub_bytes u_inv_sub_bytes (
        .i_data (w_shifted),
        .o_data (w_subbed)
    );

    assign w_keyed = w_subbed ^ i_round_key;

    always_comb begin
        w_mixed = '0;
        w_acc   = '0;
        for (int c = 0; c < c_NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_acc = '0;
                for (int j = 0; j < 4; j++) begin
                    w_acc = w_acc ^ gf_mul(w_keyed[byte_lsb(byte_idx(j, c)) +: 8],
                                           imc_coef((j - r + 4) % 4));
                end
                w_mixed[byte_lsb(byte_idx(r, c)) +: 8] = w_acc;
            end
        end
    end

    assign o_state = i_last_round ? w_keyed : w_mixed;

endmodule

`default_nettype wire

// File: rtl/aes_inv_sub_bytes.sv
// ============================================================================
// aes_inv_sub_bytes : InvSubBytes over a full 128-bit state.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_inv_sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] i_data,
    output logic [127:0] o_data
);

    for (genvar k = 0; k < c_NBYTES; k++) begin : g_byte
        assign o_data[byte_lsb(k) +: 8] = inv_sbox(i_data[byte_lsb(k) +: 8]);
    end

endmodule

`default_nettype wire

// File: rtl/aes_inv_round_ctrl.sv
// ============================================================================
// aes_inv_round_ctrl : iterative AES inverse-cipher sequencer, one round per
//                      clock, round keys fetched by index from a key store.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_inv_round_ctrl
    import aes_pkg::*;
#(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!rounds_legal(ROUNDS)) begin : g_bad_rounds
        $error("aes_inv_round_ctrl: ROUNDS must be 10, 12 or 14");
    end

    localparam logic [3:0] c_KEY_FIRST = 4'(ROUNDS);
    localparam logic [3:0] c_RND_START = 4'(ROUNDS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_rnd;
    logic [3:0] w_rnd_nxt;
    block_t     r_state_reg;
    block_t     w_state_reg_nxt;
    block_t     r_out_data;
    logic       w_load_out;
    logic       w_last_round;
    block_t     w_dp_out;

    aes_inv_round_dp u_dp (
        .i_state      (r_state_reg),
        .i_round_key  (round_key),
        .i_last_round (w_last_round),
        .o_state      (w_dp_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rnd       <= '0;
            r_state_reg <= '0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rnd       <= w_rnd_nxt;
            r_state_reg <= w_state_reg_nxt;
            if (w_load_out) r_out_data <= w_dp_out;
        end
    end

    // key_idx depends only on r_state/r_rnd so the key-store lookup cannot loop.
    always_comb begin
        w_state_nxt     = r_state;
        w_rnd_nxt       = r_rnd;
        w_state_reg_nxt = r_state_reg;
        w_load_out      = 1'b0;
        w_last_round    = 1'b0;
        key_idx         = c_KEY_FIRST;
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        busy            = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_reg_nxt = in_data ^ round_key;
                    w_rnd_nxt       = c_RND_START;
                    w_state_nxt     = ROUND;
                end
            end
            ROUND: begin
                key_idx         = r_rnd;
                w_state_reg_nxt = w_dp_out;
                if (r_rnd == 4'd1) begin
                    w_state_nxt = FINAL;
                end else begin
                    w_rnd_nxt = r_rnd - 4'd1;
                end
            end
            FINAL: begin
                key_idx         = 4'd0;
                w_last_round    = 1'b1;
                w_state_reg_nxt = w_dp_out;
                w_load_out      = 1'b1;
                w_state_nxt     = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign out_data = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_round_ctrl.sv
// Scoreboard bench: forward-AES reference model produces ciphertext/plaintext
// pairs for an AES-128 and an AES-256 instance of the decryption sequencer.
`default_nettype none

module tb_aes_inv_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [127:0] in_data   [2];
    logic [3:0]   key_idx   [2];
    logic [127:0] round_key [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [127:0] out_data  [2];
    logic         busy      [2];

    bit [127:0] ks [2][16];
    bit [127:0] exp_q [2][$];
    int         acc_q [2][$];
    int         rdy_mode [2];
    bit [7:0]   sbox [256];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    localparam bit [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam bit [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam bit [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign round_key[0] = ks[0][key_idx[0]];
    assign round_key[1] = ks[1][key_idx[1]];

    aes_inv_round_ctrl #(.ROUNDS(10)) dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .key_idx(key_idx[0]), .round_key(round_key[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0])
    );

    aes_inv_round_ctrl #(.ROUNDS(14)) dut14 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .key_idx(key_idx[1]), .round_key(round_key[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1])
    );

    function automatic int nr_of(int d);
        return (d != 0) ? 14 : 10;
    endfunction

    // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic bit [7:0] gmul(bit [7:0] a, bit [7:0] b);
        bit [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic bit [7:0] rotl8(bit [7:0] v, int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic bit [31:0] subw(bit [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic bit [7:0] gb(bit [127:0] b, int k);
        return b[127 - 8 * k -: 8];
    endfunction

    task automatic build_sbox();
        bit [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(int d, bit [255:0] key);
        bit [31:0] w [60];
        bit [31:0] t;
        bit [7:0]  rc;
        int nk;
        int nr;
        nk = (d != 0) ? 8 : 4;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32 * i -: 32];
            end else begin
                t = w[i - 1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i - nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) ks[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic bit [127:0] enc(int d, bit [127:0] pt);
        bit [7:0]   s [4][4];
        bit [7:0]   t [4][4];
        bit [127:0] st;
        int nr;
        nr = nr_of(d);
        st = pt ^ ks[d][0];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r][c] = sbox[gb(st, 4 * c + r)];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r][c] = s[r][(c + r) % 4];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = (rd == nr) ? t[r][c] :
                              gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03) ^
                              t[(r+2)%4][c] ^ t[(r+3)%4][c];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[127 - 8 * (4 * c + r) -: 8] = s[r][c];
            st = st ^ ks[d][rd];
        end
        return st;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic fail_now(string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic monitor();
        bit [127:0] prev_data [2];
        bit         prev_hold [2];
        bit         prev_ov   [2];
        bit         ktrack    [2];
        int         kcnt      [2];
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    prev_hold[d] = 1'b0;
                    prev_ov[d]   = 1'b0;
                    ktrack[d]    = 1'b0;
                    acc_q[d].delete();
                end else begin
                    if (ktrack[d] && busy[d] && !out_valid[d]) begin
                        kcnt[d]++;
                        chk("key_idx_seq", key_idx[d], nr_of(d) - kcnt[d]);
                    end
                    if (in_valid[d] && in_ready[d]) begin
                        chk("key_idx_accept", key_idx[d], nr_of(d));
                        acc_q[d].push_back(cyc + 1);
                        ktrack[d] = 1'b1;
                        kcnt[d]   = 0;
                    end
                    if (out_valid[d] && !prev_ov[d]) begin
                        if (acc_q[d].size() == 0) fail_now("latency_no_accept");
                        else chk("latency", (cyc + 1) - acc_q[d].pop_front(), nr_of(d) + 1);
                        chk("key_idx_count", kcnt[d], nr_of(d));
                        ktrack[d] = 1'b0;
                    end
                    if (prev_hold[d]) begin
                        chk("hold_valid", out_valid[d], 1);
                        chk("hold_data", out_data[d], prev_data[d]);
                    end
                    if (out_valid[d]) chk("in_ready_in_done", in_ready[d], 0);
                    if (out_valid[d] && out_ready[d]) begin
                        if (exp_q[d].size() == 0) fail_now("unexpected_output");
                        else chk("plaintext", out_data[d], exp_q[d].pop_front());
                    end
                    prev_hold[d] = out_valid[d] && !out_ready[d];
                    prev_data[d] = out_data[d];
                    prev_ov[d]   = out_valid[d];
                end
            end
        end
    endtask

    task automatic drive_ready();
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                out_ready[d] = (rdy_mode[d] == 2) ? ($urandom_range(0, 1) == 1) : (rdy_mode[d] == 1);
        end
    endtask

    task automatic send(int d, bit [127:0] data, bit [127:0] expv, bit hold, output int edge_no);
        int n;
        n = 0;
        edge_no = -1;
        @(posedge clk);
        #1;
        in_data[d]  = data;
        in_valid[d] = 1'b1;
        exp_q[d].push_back(expv);
        forever begin
            @(negedge clk);
            if (in_ready[d]) begin
                edge_no = cyc + 1;
                break;
            end
            n++;
            if (n > 500) begin
                fail_now("accept_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!hold) in_valid[d] = 1'b0;
    endtask

    task automatic drain(int d);
        int n;
        n = 0;
        while (exp_q[d].size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q[d].size() != 0) begin
            fail_now("drain_timeout");
            exp_q[d].delete();
        end
    endtask

    initial begin
        int e1;
        int e2;
        int n;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            out_ready[d] = 1'b1;
            rdy_mode[d]  = 1;
        end
        build_sbox();
        fork
            monitor();
            drive_ready();
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", in_ready[d], 1);
            chk("rst_busy", busy[d], 0);
            chk("rst_key_idx", key_idx[d], nr_of(d));
            chk("rst_out_valid", out_valid[d], 0);
            chk("rst_out_data", out_data[d], 0);
        end

        // FIPS-197 C.1 and C.3 known answers
        expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        expand(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        send(0, C1_CT, PT, 1'b0, e1);
        send(1, C3_CT, PT, 1'b0, e1);
        drain(0);
        drain(1);

        // Backpressure in DONE with an ignored in_valid pulse
        rdy_mode[0] = 0;
        send(0, C1_CT, PT, 1'b0, e1);
        n = 0;
        while (!out_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid[0]) fail_now("bp_wait_valid");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid[0] = (i == 2);
            in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("bp_out_valid", out_valid[0], 1);
        end
        in_valid[0] = 1'b0;
        rdy_mode[0] = 1;
        drain(0);
        @(negedge clk);
        chk("bp_in_ready_after", in_ready[0], 1);
        chk("bp_busy_after", busy[0], 0);

        // Reset in the middle of a block (rnd == 5)
        send(0, C1_CT, PT, 1'b0, e1);
        n = 0;
        while (key_idx[0] != 4'd6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (key_idx[0] != 4'd6) fail_now("wait_rnd6");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q[0].delete();
        @(negedge clk);
        chk("midrst_busy", busy[0], 0);
        chk("midrst_out_valid", out_valid[0], 0);
        chk("midrst_out_data", out_data[0], 0);
        chk("midrst_in_ready", in_ready[0], 1);
        send(0, C1_CT, PT, 1'b0, e1);
        drain(0);

        // Back-to-back with in_valid held high
        send(0, C1_CT, PT, 1'b1, e1);
        send(0, C1_CT, PT, 1'b0, e2);
        chk("b2b_interval", e2 - e1, 12);
        drain(0);

        // Randomized keys, plaintexts, gaps and output backpressure
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                bit [255:0] key;
                bit [127:0] pt;
                drain(d);
                key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                expand(d, key);
                rdy_mode[d] = 2;
                for (int b = 0; b < 4; b++) begin
                    pt = {$urandom, $urandom, $urandom, $urandom};
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send(d, enc(d, pt), pt, 1'b0, e1);
                end
                drain(d);
                rdy_mode[d] = 1;
            end
        end

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
